io_port_ctrl: RTL and testbench

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/invaders_pkg.sv | 36 +++
 rtl/io_debounce.sv | 57 +++++
 rtl/io_port_ctrl.sv | 174 +++++++++++++++++
 tb/tb_io_port_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
`default_nettype none
// ============================================================================
// Module      : invaders_pkg
// Description : Shared I/O port map, IN port 0 constant and switch indices
//               for the cabinet I/O controller.
// Revision    : 1.0 - initial release
// ============================================================================
package invaders_pkg;

  // OUT port numbers decoded by the controller; all other ports are ignored
  localparam logic [7:0] PORT_SH_OFFSET = 8'd2;
  localparam logic [7:0] PORT_SND1      = 8'd3;
  localparam logic [7:0] PORT_SH_DATA   = 8'd4;
  localparam logic [7:0] PORT_SND2      = 8'd5;
  localparam logic [7:0] PORT_WDT       = 8'd6;

  // IN port numbers
  localparam logic [7:0] IN_PORT0      = 8'd0;
  localparam logic [7:0] IN_PORT1      = 8'd1;
  localparam logic [7:0] IN_PORT2      = 8'd2;
  localparam logic [7:0] IN_PORT_SHIFT = 8'd3;

  // Fixed value returned on IN port 0
  localparam logic [7:0] IN_PORT0_VAL = 8'h0E;

  // Bit positions of each cabinet switch in the debouncer bank
  localparam int NUM_SW      = 10;
  localparam int SW_COIN     = 0;
  localparam int SW_P1_START = 1;
  localparam int SW_P2_START = 2;
  localparam int SW_TILT     = 3;
  localparam int SW_P1_BTN   = 4;  // 3 bits {right,left,fire} at 6:4
  localparam int SW_P2_BTN   = 7;  // 3 bits {right,left,fire} at 9:7

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module      : io_debounce
// Description : Two-flop synchroniser followed by a counter debouncer. The
//               output only follows the input after DEBOUNCE_CYC consecutive
//               cycles of disagreement; any agreeing cycle restarts the count.
//               DEBOUNCE_CYC must be at least 1.
// Revision    : 1.0 - initial release
// ============================================================================
module io_debounce #(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_deb
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        deb_q, deb_d;
  logic [15:0] cnt_q, cnt_d;

  // Synchronise the raw switch and count consecutive cycles of disagreement
  always_comb begin
    sync1_d = i_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q >= DEBOUNCE_CYC - 16'd1) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // State registers, cleared to the released (0) level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_deb = deb_q;

endmodule
`default_nettype wire

// File: rtl/io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_port_ctrl
// Description : CPU I/O port controller: OUT write decode (shifter, sound
//               latches, watchdog kick), IN read mux, debounced cabinet
//               switches with coin credit hold, and a watchdog timer.
// Revision    : 1.0 - initial release
// ============================================================================
module io_port_ctrl
  import invaders_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYC  = 16'd50000,
  parameter logic [23:0] COIN_HOLD_CYC = 24'd2000000,
  parameter logic [31:0] WDT_CYC       = 32'd50000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_port,
  input  logic [7:0] i_data,
  input  logic       i_out_stb,
  input  logic       i_in_stb,
  output logic [7:0] o_data,
  input  logic       i_coin,
  input  logic       i_p1_start,
  input  logic       i_p2_start,
  input  logic       i_tilt,
  input  logic [2:0] i_p1_btn,
  input  logic [2:0] i_p2_btn,
  input  logic [3:0] i_dip,
  output logic       o_sh_wr_data,
  output logic       o_sh_wr_offset,
  output logic [7:0] o_sh_data,
  input  logic [7:0] i_sh_data,
  output logic [7:0] o_snd1,
  output logic [7:0] o_snd2,
  output logic [7:0] o_snd1_trig,
  output logic [7:0] o_snd2_trig,
  output logic       o_wdt_expire
);

  logic              stb_q, stb_d;
  logic              wr_q, wr_d;
  logic [7:0]        port_q, port_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        snd1_q, snd1_d, snd2_q, snd2_d;
  logic [7:0]        trig1_q, trig1_d, trig2_q, trig2_d;
  logic [31:0]       wdt_q, wdt_d;
  logic              expire_q, expire_d;
  logic              coin_prev_q, coin_prev_d;
  logic [23:0]       credit_cnt_q, credit_cnt_d;
  logic [NUM_SW-1:0] sw_raw, sw_deb;
  logic              credit;
  logic              wr_snd1, wr_snd2, wr_wdt;
  logic              unused_in_stb;

  // The IN strobe carries no information: the read mux follows i_port alone
  assign unused_in_stb = i_in_stb;

  assign sw_raw = {i_p2_btn, i_p1_btn, i_tilt, i_p2_start, i_p1_start, i_coin};

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_deb
    io_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_raw(sw_raw[gi]),
      .o_deb(sw_deb[gi])
    );
  end

  // Write cycle decode: wr_q is high for exactly one cycle after a strobe rise
  assign wr_snd1        = wr_q && (port_q == PORT_SND1);
  assign wr_snd2        = wr_q && (port_q == PORT_SND2);
  assign wr_wdt         = wr_q && (port_q == PORT_WDT);
  assign o_sh_wr_offset = wr_q && (port_q == PORT_SH_OFFSET);
  assign o_sh_wr_data   = wr_q && (port_q == PORT_SH_DATA);
  assign o_sh_data      = data_q;

  assign credit = (credit_cnt_q != '0);

  // Next-state for OUT capture, sound latches, watchdog and coin credit
  always_comb begin
    stb_d        = i_out_stb;
    wr_d         = i_out_stb && !stb_q;
    port_d       = port_q;
    data_d       = data_q;
    snd1_d       = snd1_q;
    snd2_d       = snd2_q;
    trig1_d      = '0;
    trig2_d      = '0;
    wdt_d        = wdt_q - 32'd1;
    expire_d     = 1'b0;
    coin_prev_d  = sw_deb[SW_COIN];
    credit_cnt_d = credit ? credit_cnt_q - 24'd1 : credit_cnt_q;

    if (wr_d) begin
      port_d = i_port;
      data_d = i_data;
    end
    if (wr_snd1) begin
      snd1_d  = data_q;
      trig1_d = data_q & ~snd1_q;
    end
    if (wr_snd2) begin
      snd2_d  = data_q;
      trig2_d = data_q & ~snd2_q;
    end
    // A kick landing on the terminal count wins over the expiry
    if (wr_wdt) begin
      wdt_d = WDT_CYC;
    end else if (wdt_q <= 32'd1) begin
      wdt_d    = WDT_CYC;
      expire_d = 1'b1;
    end
    // Each debounced coin press (re)starts the credit hold
    if (sw_deb[SW_COIN] && !coin_prev_q) begin
      credit_cnt_d = COIN_HOLD_CYC;
    end
  end

  // State registers; the strobe history resets high so a held strobe is not a write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stb_q        <= 1'b1;
      wr_q         <= 1'b0;
      port_q       <= '0;
      data_q       <= '0;
      snd1_q       <= '0;
      snd2_q       <= '0;
      trig1_q      <= '0;
      trig2_q      <= '0;
      wdt_q        <= WDT_CYC;
      expire_q     <= 1'b0;
      coin_prev_q  <= 1'b0;
      credit_cnt_q <= '0;
    end else begin
      stb_q        <= stb_d;
      wr_q         <= wr_d;
      port_q       <= port_d;
      data_q       <= data_d;
      snd1_q       <= snd1_d;
      snd2_q       <= snd2_d;
      trig1_q      <= trig1_d;
      trig2_q      <= trig2_d;
      wdt_q        <= wdt_d;
      expire_q     <= expire_d;
      coin_prev_q  <= coin_prev_d;
      credit_cnt_q <= credit_cnt_d;
    end
  end

  assign o_snd1       = snd1_q;
  assign o_snd2       = snd2_q;
  assign o_snd1_trig  = trig1_q;
  assign o_snd2_trig  = trig2_q;
  assign o_wdt_expire = expire_q;

  // IN read mux, purely combinational on the port address
  always_comb begin
    o_data = 8'h00;
    case (i_port)
      IN_PORT0:      o_data = IN_PORT0_VAL;
      IN_PORT1:      o_data = {1'b1, sw_deb[SW_P1_BTN +: 3], 1'b1,
                               sw_deb[SW_P1_START], sw_deb[SW_P2_START], credit};
      IN_PORT2:      o_data = {i_dip[3], sw_deb[SW_P2_BTN +: 3], i_dip[2],
                               sw_deb[SW_TILT], i_dip[1:0]};
      IN_PORT_SHIFT: o_data = i_sh_data;
      default:       o_data = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_io_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_port_ctrl
// Description : Directed self-checking bench for io_port_ctrl with short
//               debounce, coin hold and watchdog periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_port_ctrl;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_port;
  logic [7:0] i_data;
  logic       i_out_stb;
  logic       i_in_stb;
  logic [7:0] o_data;
  logic       i_coin, i_p1_start, i_p2_start, i_tilt;
  logic [2:0] i_p1_btn, i_p2_btn;
  logic [3:0] i_dip;
  logic       o_sh_wr_data, o_sh_wr_offset;
  logic [7:0] o_sh_data;
  logic [7:0] i_sh_data;
  logic [7:0] o_snd1, o_snd2, o_snd1_trig, o_snd2_trig;
  logic       o_wdt_expire;

  int         n_checks, n_fail;
  int         found, gap, first, n_exp, n_pulse, n_off, hi, lat, done, bad;
  logic [7:0] sh_seen;

  io_port_ctrl #(
    .DEBOUNCE_CYC (16'd4),
    .COIN_HOLD_CYC(24'd20),
    .WDT_CYC      (32'd10)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_port        (i_port),
    .i_data        (i_data),
    .i_out_stb     (i_out_stb),
    .i_in_stb      (i_in_stb),
    .o_data        (o_data),
    .i_coin        (i_coin),
    .i_p1_start    (i_p1_start),
    .i_p2_start    (i_p2_start),
    .i_tilt        (i_tilt),
    .i_p1_btn      (i_p1_btn),
    .i_p2_btn      (i_p2_btn),
    .i_dip         (i_dip),
    .o_sh_wr_data  (o_sh_wr_data),
    .o_sh_wr_offset(o_sh_wr_offset),
    .o_sh_data     (o_sh_data),
    .i_sh_data     (i_sh_data),
    .o_snd1        (o_snd1),
    .o_snd2        (o_snd2),
    .o_snd1_trig   (o_snd1_trig),
    .o_snd2_trig   (o_snd2_trig),
    .o_wdt_expire  (o_wdt_expire)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One OUT cycle; on return the sound latches/trigs of that write are visible
  task automatic do_out(input logic [7:0] port, input logic [7:0] data);
    i_port    = port;
    i_data    = data;
    i_out_stb = 1'b1;
    tick();
    i_out_stb = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0;
    i_rst = 1'b1; i_port = '0; i_data = '0; i_out_stb = 1'b0; i_in_stb = 1'b0;
    i_coin = 1'b0; i_p1_start = 1'b0; i_p2_start = 1'b0; i_tilt = 1'b0;
    i_p1_btn = '0; i_p2_btn = '0; i_dip = '0; i_sh_data = '0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_snd1", o_snd1, 8'h00);
    check_eq("rst_snd2", o_snd2, 8'h00);
    check_eq("rst_trigs", {o_snd1_trig, o_snd2_trig}, 16'h0000);
    check_eq("rst_sh_strobes", {o_sh_wr_data, o_sh_wr_offset}, 2'b00);
    check_eq("rst_expire", o_wdt_expire, 1'b0);
    i_port = 8'd1; #1;
    check_eq("rst_port1", o_data, 8'h88);
    i_rst = 1'b0;

    // Free-running watchdog: first pulse 10 cycles after release, then every 10
    first = 0;
    for (int k = 1; k <= 30 && first == 0; k++) begin
      tick();
      if (o_wdt_expire) first = k;
    end
    check_eq("wdt_first", first, 10);
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      for (int k = 1; k <= 30 && gap == 0; k++) begin
        tick();
        if (o_wdt_expire) gap = k;
      end
      check_eq("wdt_period", gap, 10);
    end
    tick();
    check_eq("wdt_pulse_width", o_wdt_expire, 1'b0);

    // Kicks every 8 cycles, then every 10 (each kick lands on the terminal count)
    i_port = 8'd6; i_data = 8'h00; n_exp = 0;
    for (int it = 0; it < 6; it++) begin
      i_out_stb = 1'b1; tick(); if (o_wdt_expire) n_exp++;
      i_out_stb = 1'b0;
      for (int k = 0; k < 7; k++) begin tick(); if (o_wdt_expire) n_exp++; end
    end
    check_eq("wdt_kick8", n_exp, 0);
    n_exp = 0;
    for (int it = 0; it < 4; it++) begin
      i_out_stb = 1'b1; tick(); if (o_wdt_expire) n_exp++;
      i_out_stb = 1'b0;
      for (int k = 0; k < 9; k++) begin tick(); if (o_wdt_expire) n_exp++; end
    end
    check_eq("wdt_kick_at_zero", n_exp, 0);

    // OUT 4 = AB with strobe held 5 cycles
    i_port = 8'd4; i_data = 8'hAB; i_out_stb = 1'b1;
    n_pulse = 0; n_off = 0; sh_seen = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 4) i_out_stb = 1'b0;
      if (o_sh_wr_data) begin n_pulse++; sh_seen = o_sh_data; end
      if (o_sh_wr_offset) n_off++;
    end
    check_eq("sh_data_pulses", n_pulse, 1);
    check_eq("sh_data_value", sh_seen, 8'hAB);
    check_eq("sh_data_no_offset", n_off, 0);

    // OUT 2 = 33 with strobe held 2 cycles
    i_port = 8'd2; i_data = 8'h33; i_out_stb = 1'b1;
    n_pulse = 0; n_off = 0; sh_seen = 8'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) i_out_stb = 1'b0;
      if (o_sh_wr_offset) begin n_off++; sh_seen = o_sh_data; end
      if (o_sh_wr_data) n_pulse++;
    end
    check_eq("sh_off_pulses", n_off, 1);
    check_eq("sh_off_value", sh_seen, 8'h33);
    check_eq("sh_off_no_data", n_pulse, 0);

    // Sound latches and rising-bit triggers
    do_out(8'd5, 8'h05);
    check_eq("snd2_a", o_snd2, 8'h05);
    check_eq("snd2_trig_a", o_snd2_trig, 8'h05);
    check_eq("snd1_untouched", {o_snd1, o_snd1_trig}, 16'h0000);
    tick();
    check_eq("snd2_trig_one_cycle", o_snd2_trig, 8'h00);
    do_out(8'd5, 8'h07);
    check_eq("snd2_b", o_snd2, 8'h07);
    check_eq("snd2_trig_b", o_snd2_trig, 8'h02);
    do_out(8'd3, 8'hFF);
    check_eq("snd1_ff", o_snd1, 8'hFF);
    check_eq("snd1_trig_ff", o_snd1_trig, 8'hFF);
    do_out(8'd7, 8'h11);
    check_eq("out7_ignored", {o_snd1, o_snd2, o_snd1_trig, o_snd2_trig}, 32'hFF07_0000);

    // IN read mux
    i_in_stb = 1'b1; i_sh_data = 8'h5A; i_dip = 4'b1010;
    i_port = 8'd3; #1; check_eq("in3_shift", o_data, 8'h5A);
    i_port = 8'd9; #1; check_eq("in9_zero", o_data, 8'h00);
    i_port = 8'd0; #1; check_eq("in0_const", o_data, 8'h0E);
    i_port = 8'd2; #1; check_eq("in2_dips", o_data, 8'h82);
    i_in_stb = 1'b0;

    // Bouncing coin must never produce credit
    i_port = 8'd1; bad = 0;
    for (int k = 0; k < 6; k++) begin
      i_coin = 1'b1; tick(); bad |= int'(o_data[0]); tick(); bad |= int'(o_data[0]);
      i_coin = 1'b0; tick(); bad |= int'(o_data[0]); tick(); bad |= int'(o_data[0]);
    end
    check_eq("coin_bounce_no_credit", bad, 0);

    // Stable press: 2 sync + 4 debounce cycles, credit visible on the 7th
    i_coin = 1'b1; lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (o_data[0]) lat = k;
    end
    check_eq("credit_latency", lat, 7);
    hi = 1; done = 0;
    for (int k = 1; k <= 60 && done == 0; k++) begin
      tick();
      if (k == 3) i_coin = 1'b0;
      if (o_data[0]) hi++; else done = 1;
    end
    check_eq("credit_hold", hi, 20);

    // Second press during the hold restarts it: 13 + 20 high cycles
    i_coin = 1'b1; lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (o_data[0]) lat = k;
    end
    check_eq("credit_latency2", lat, 7);
    i_coin = 1'b0; hi = 1; done = 0;
    for (int k = 1; k <= 80 && done == 0; k++) begin
      tick();
      if (k == 6) i_coin = 1'b1;
      if (o_data[0]) hi++; else done = 1;
    end
    check_eq("credit_restart", hi, 33);

    // Player switches through the debouncers
    i_coin = 1'b0; i_p1_start = 1'b1; i_p2_start = 1'b1; i_tilt = 1'b1;
    i_p1_btn = 3'b101; i_p2_btn = 3'b010; i_dip = 4'b1010;
    i_port = 8'd1;
    repeat (2) tick();
    check_eq("sw_not_yet", o_data, 8'h88);
    repeat (10) tick();
    check_eq("port1_switches", o_data, 8'hDE);
    i_port = 8'd2; #1;
    check_eq("port2_switches", o_data, 8'hA6);

    // Reset in the middle of OUT 3 with strobe held through release
    i_port = 8'd3; i_data = 8'hC3; i_out_stb = 1'b1;
    tick();
    i_rst = 1'b1;
    tick();
    check_eq("midrst_snd1", o_snd1, 8'h00);
    check_eq("midrst_trig1", o_snd1_trig, 8'h00);
    check_eq("midrst_expire", o_wdt_expire, 1'b0);
    i_port = 8'd1; #1;
    check_eq("midrst_port1", o_data, 8'h88);
    i_port = 8'd3;
    tick();
    i_rst = 1'b0; bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_snd1 != 8'h00 || o_snd1_trig != 8'h00) bad++;
    end
    check_eq("held_stb_no_write", bad, 0);
    i_out_stb = 1'b0;
    tick();
    do_out(8'd3, 8'hC3);
    check_eq("post_rst_write", {o_snd1, o_snd1_trig}, 16'hC3C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
